// File: rtl/shift_unit.sv
// shift_unit: multicycle SLL/SRL/SRA/ROR unit that moves one bit position per clock
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [SHW-1:0] cnt;
    logic [1:0] op_q;
    logic [WIDTH-1:0] stepped;
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    always_comb begin
        state_nx = IDLE;
        state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
                   state == SHIFT ? (cnt == '0 ? DONE : SHIFT) : IDLE;
    end
    always_comb begin
        stepped = '0;
        stepped = op_q == 2'b00 ? {data_out[WIDTH-2:0], 1'b0} :
                  op_q == 2'b01 ? {1'b0, data_out[WIDTH-1:1]} :
                  op_q == 2'b10 ? {data_out[WIDTH-1], data_out[WIDTH-1:1]} :
                                  {data_out[0], data_out[WIDTH-1:1]};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            cnt      <= '0;
            op_q     <= '0;
        end else if (state == IDLE && start) begin
            data_out <= data_in;
            cnt      <= shamt;
            op_q     <= op;
        end else if (state == SHIFT && cnt != '0) begin
            data_out <= stepped;
            cnt      <= cnt - 1'b1;
        end
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: randomized self-checking bench against an arithmetic shift model
module tb_shift_unit;
    logic        clk = 0;
    logic        reset = 1;
    logic        start = 0;
    logic [1:0]  op = 0;
    logic [4:0]  shamt = 0;
    logic [31:0] data_in = 0;
    logic [31:0] data_out;
    logic        busy, done;
    int tests = 0;
    int fails = 0;

    shift_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
        .data_in(data_in), .data_out(data_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input int n, input logic [31:0] d);
        logic [63:0] rot;
        rot = {d, d} >> n;
        return o == 2'b00 ? d << n :
               o == 2'b01 ? d >> n :
               o == 2'b10 ? 32'($signed(d) >>> n) : rot[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the unit idle; drives one operation to completion.
    task automatic run_op(input logic [1:0] o, input int n, input logic [31:0] d, input bit inject);
        logic [31:0] exp;
        int edges;
        exp = ref_shift(o, n, d);
        op = o; shamt = 5'(n); data_in = d; start = 1;
        tick();
        start = inject;
        op = 2'($urandom); shamt = 5'd1; data_in = inject ? 32'h12345678 : $urandom;
        check("busy_after_load", {31'b0, busy}, 32'd1);
        edges = 0;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
        check("latency", edges, n + 1);
        check("result", data_out, exp);
        check("busy_in_done", {31'b0, busy}, 32'd1);
        tick();
        start = 0;
        check("done_single", {31'b0, done}, 32'd0);
        check("busy_idle", {31'b0, busy}, 32'd0);
        tick();
        check("no_second_op", {30'b0, busy, done}, 32'd0);
        check("result_hold", data_out, exp);
    endtask

    initial begin
        int seen;
        tick();
        tick();
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("reset_idle", {data_out[31:0]}, 32'd0);
            check("reset_flags", {30'b0, busy, done}, 32'd0);
        end
        run_op(2'b00, 4, 32'h00000001, 0);
        check("sll_dir", data_out, 32'h00000010);
        run_op(2'b10, 31, 32'h80000000, 0);
        check("sra_max", data_out, 32'hFFFFFFFF);
        run_op(2'b01, 31, 32'h80000000, 0);
        check("srl_max", data_out, 32'h00000001);
        run_op(2'b11, 1, 32'h00000001, 0);
        check("ror1", data_out, 32'h80000000);
        run_op(2'b00, 0, 32'hDEADBEEF, 0);
        check("zero_shift", data_out, 32'hDEADBEEF);
        run_op(2'b11, 31, 32'h80000001, 0);
        check("ror31_rol1", data_out, 32'h00000003);
        run_op(2'b00, 8, 32'h000000FF, 1);
        check("start_ignored", data_out, 32'h0000FF00);
        // Abort an SRL-by-20 with reset at E3.
        op = 2'b01; shamt = 5'd20; data_in = 32'hF0F0F0F0; start = 1;
        tick();
        start = 0;
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0;
        check("abort_data", data_out, 32'd0);
        check("abort_flags", {30'b0, busy, done}, 32'd0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            seen += {31'b0, done | busy};
        end
        check("abort_no_done", seen, 0);
        run_op(2'b10, 3, 32'h8000_0010, 0);
        for (int i = 0; i < 25; i++)
            run_op(2'($urandom), int'($urandom_range(0, 31)), $urandom, 1'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
